alu_csr_exec_unit: RTL and testbench
====================================

Name: alu_csr_exec_unit

Overview:
- Execute-stage datapath slice for the RV32I pipeline.
- Combines three parts:
  - a combinational 32-bit ALU, which also produces branch-compare flags;
  - combinational CSR write-value generation for CSRRW/S/C and their immediate forms;
  - a machine-mode CSR register file, read by ID and written from EX.
- ID reads CSRs through the read port. EX supplies operands and the CSR write command.

Parameters:
- MISA_RESET, 32'h4000_0100, read-only misa value (RV32, I extension).
- HART_ID, 32'h0, value returned by mhartid.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- alu_op  input  4  ALU operation code.
- src1  input  32  ALU operand 1.
- src2  input  32  ALU operand 2.
- alu_result  output  32  ALU result (combinational).
- csr_funct  input  3  instruction funct3 of the CSR op.
- csr_val  input  32  old CSR value, as read in ID.
- rs1_val  input  32  forwarded rs1 value.
- imm  input  32  immediate; bits [4:0] are the zimm field.
- csr_result  output  32  new CSR value (combinational).
- csr_r_addr  input  12  CSR read address (ID stage).
- csr_r_val  output  32  CSR read data (combinational).
- csr_w_addr  input  12  CSR write address (EX stage).
- w_enable  input  1  write csr_result to csr_w_addr on the next rising edge.
- debug_mstatus  output  32  current mstatus value.
- debug_misa  output  32  current misa value.

Behaviour:
- ALU, purely combinational. Shift amount is src2[4:0]. Compare results are 32'd1 or 32'd0.
  - 0 ADD; 1 SUB; 2 SLL; 3 SLT (signed); 4 SLTU; 5 XOR; 6 SRL; 7 SRA; 8 OR; 9 AND.
  - 10 EQ; 11 NE; 12 GE (signed); 13 GEU.
  - 14 reserved -> 0; 15 NONE -> 0.
  - Add/sub wrap modulo 2^32; no flags.
  - BLT/BLTU use SLT/SLTU.
- CSR mask, combinational. zimm = {27'b0, imm[4:0]}.
  - 001 CSRRW -> rs1_val.
  - 010 CSRRS -> csr_val | rs1_val.
  - 011 CSRRC -> csr_val & ~rs1_val.
  - 101 -> zimm.
  - 110 -> csr_val | zimm.
  - 111 -> csr_val & ~zimm.
  - 000 and 100 -> csr_val (no change).
- CSR file: implemented registers, addresses, reset values:
  - mstatus 0x300, reset 0x0000_1800. Writable bits: MIE[3] and MPIE[7]. MPP[12:11] always reads 2'b11. All other bits read 0.
  - misa 0x301 = MISA_RESET; writes ignored.
  - mie 0x304, mtvec 0x305, mscratch 0x340, mcause 0x342, mtval 0x343, mip 0x344: full 32-bit read/write, reset 0.
  - mepc 0x341: read/write, reset 0, bits [1:0] forced to 0.
  - mcycle 0xB00 / mcycleh 0xB80: 64-bit counter, reset 0. Increments by 1 every cycle. Carry passes from low to high word.
  - cycle 0xC00 / cycleh 0xC80: read-only aliases of mcycle/mcycleh.
  - mhartid 0xF14 = HART_ID, read-only.
- Unimplemented or read-only addresses: reads return 0 (read-only ones return their value); writes are silently ignored. No exceptions are raised.
- Write timing: when w_enable=1, the masked csr_result is stored at the rising edge.
- Write-through bypass: if w_enable=1 and csr_w_addr==csr_r_addr, csr_r_val returns the masked csr_result combinationally in the same cycle.
- Write vs. counter increment on mcycle/mcycleh in the same cycle: the write wins. The written half takes the written value; the other half still increments normally, including carry from the old low word.
- Reset: when reset=0, all registers return to their reset values immediately, independent of clock. Any write in flight at that moment is discarded.
- debug_mstatus and debug_misa always reflect the stored values, without the bypass.

Test Plan:
- ALU: alu_op=1, src1=5, src2=7 -> alu_result=FFFF_FFFE. alu_op=7, src1=8000_0000, src2=0x21 -> C000_0000 (shift amount 1). alu_op=3, src1=FFFF_FFFF, src2=1 -> 1; alu_op=4 with the same operands -> 0. alu_op=15 -> 0.
- CSR mask: csr_val=F0F0, rs1_val=00FF.
  - funct 010 -> F0FF; funct 011 -> F000.
  - funct 101 with imm=0xFFFF_FFF5 -> 0x15.
  - funct 000 -> F0F0.
- Reset: assert reset=0 mid-cycle -> debug_mstatus=0000_1800 and debug_misa=4000_0100 immediately, with no clock edge.
- Write/read: write mscratch=DEAD_BEEF via funct 001, rs1_val=DEAD_BEEF, w_enable=1; csr_r_addr=0x340 in the same cycle -> bypass DEAD_BEEF; after the edge -> DEAD_BEEF.
- Masked and ignored writes: mstatus CSRRW with FFFF_FFFF -> reads 0000_1888. Write to misa or to 0x7C0 -> misa unchanged; 0x7C0 reads 0. mepc write 0000_1003 -> reads 0000_1000.
- Counter: mcycle reads N, then N+1 next cycle. Write mcycle=FFFF_FFFF -> next cycle mcycle=0 and mcycleh incremented by 1.

Source files
------------

// File: rtl/alu_csr_exec_unit.sv
// RV32I execute-stage slice: combinational ALU with branch compares, CSR
// write-value generation, and the machine-mode CSR register file.
module alu_csr_exec_unit #(
  parameter logic [31:0] MISA_RESET = 32'h4000_0100,
  parameter logic [31:0] HART_ID    = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  alu_op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic [31:0] alu_result,
  input  logic [2:0]  csr_funct,
  input  logic [31:0] csr_val,
  input  logic [31:0] rs1_val,
  input  logic [31:0] imm,
  output logic [31:0] csr_result,
  input  logic [11:0] csr_r_addr,
  output logic [31:0] csr_r_val,
  input  logic [11:0] csr_w_addr,
  input  logic        w_enable,
  output logic [31:0] debug_mstatus,
  output logic [31:0] debug_misa
);

  localparam int DATA_W = 32;

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MISA     = 12'h301;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;
  localparam logic [11:0] A_CYCLE    = 12'hC00;
  localparam logic [11:0] A_CYCLEH   = 12'hC80;
  localparam logic [11:0] A_MHARTID  = 12'hF14;

  // Only MIE/MPIE are stored; MPP is hardwired to machine mode.
  function automatic logic [DATA_W-1:0] mstatus_pack(input logic mpie, input logic mie);
    return {19'b0, 2'b11, 3'b0, mpie, 3'b0, mie, 3'b0};
  endfunction

  function automatic logic csr_is_writable(input logic [11:0] addr);
    case (addr)
      A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE,
      A_MTVAL, A_MIP, A_MCYCLE, A_MCYCLEH: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Value a register would read back after being written with data.
  function automatic logic [DATA_W-1:0] csr_wmask(input logic [11:0] addr,
                                                  input logic [DATA_W-1:0] data);
    case (addr)
      A_MSTATUS: return mstatus_pack(data[7], data[3]);
      A_MEPC:    return {data[DATA_W-1:2], 2'b00};
      default:   return data;
    endcase
  endfunction

  logic signed [DATA_W-1:0] src1_s;
  logic signed [DATA_W-1:0] src2_s;
  logic [4:0]               shamt;

  assign src1_s = src1;
  assign src2_s = src2;
  assign shamt  = src2[4:0];

  always_comb begin
    alu_result = '0;
    case (alu_op)
      4'd0:  alu_result = src1 + src2;
      4'd1:  alu_result = src1 - src2;
      4'd2:  alu_result = src1 << shamt;
      4'd3:  alu_result = {31'b0, src1_s < src2_s};
      4'd4:  alu_result = {31'b0, src1 < src2};
      4'd5:  alu_result = src1 ^ src2;
      4'd6:  alu_result = src1 >> shamt;
      4'd7:  alu_result = src1_s >>> shamt;
      4'd8:  alu_result = src1 | src2;
      4'd9:  alu_result = src1 & src2;
      4'd10: alu_result = {31'b0, src1 == src2};
      4'd11: alu_result = {31'b0, src1 != src2};
      4'd12: alu_result = {31'b0, src1_s >= src2_s};
      4'd13: alu_result = {31'b0, src1 >= src2};
      default: alu_result = '0;
    endcase
  end

  logic [DATA_W-1:0] zimm;
  logic              unused_imm_hi;

  assign zimm          = {27'b0, imm[4:0]};
  assign unused_imm_hi = ^imm[31:5];

  always_comb begin
    csr_result = csr_val;
    case (csr_funct)
      3'b001: csr_result = rs1_val;
      3'b010: csr_result = csr_val | rs1_val;
      3'b011: csr_result = csr_val & ~rs1_val;
      3'b101: csr_result = zimm;
      3'b110: csr_result = csr_val | zimm;
      3'b111: csr_result = csr_val & ~zimm;
      default: csr_result = csr_val;
    endcase
  end

  logic              mstatus_mie;
  logic              mstatus_mpie;
  logic [DATA_W-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q, mip_q;
  logic [DATA_W-1:0] mcycle_lo, mcycle_hi;
  logic [DATA_W-1:0] mstatus_val;
  logic [DATA_W-1:0] csr_rd_stored;

  assign mstatus_val   = mstatus_pack(mstatus_mpie, mstatus_mie);
  assign debug_mstatus = mstatus_val;
  assign debug_misa    = MISA_RESET;

  always_comb begin
    csr_rd_stored = '0;
    case (csr_r_addr)
      A_MSTATUS:           csr_rd_stored = mstatus_val;
      A_MISA:              csr_rd_stored = MISA_RESET;
      A_MIE:               csr_rd_stored = mie_q;
      A_MTVEC:             csr_rd_stored = mtvec_q;
      A_MSCRATCH:          csr_rd_stored = mscratch_q;
      A_MEPC:              csr_rd_stored = mepc_q;
      A_MCAUSE:            csr_rd_stored = mcause_q;
      A_MTVAL:             csr_rd_stored = mtval_q;
      A_MIP:               csr_rd_stored = mip_q;
      A_MCYCLE, A_CYCLE:   csr_rd_stored = mcycle_lo;
      A_MCYCLEH, A_CYCLEH: csr_rd_stored = mcycle_hi;
      A_MHARTID:           csr_rd_stored = HART_ID;
      default:             csr_rd_stored = '0;
    endcase
  end

  // Same-cycle write from EX is forwarded to the ID read port.
  assign csr_r_val = (w_enable && (csr_w_addr == csr_r_addr) && csr_is_writable(csr_w_addr))
                     ? csr_wmask(csr_w_addr, csr_result) : csr_rd_stored;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_q        <= '0;
      mtvec_q      <= '0;
      mscratch_q   <= '0;
      mepc_q       <= '0;
      mcause_q     <= '0;
      mtval_q      <= '0;
      mip_q        <= '0;
      mcycle_lo    <= '0;
      mcycle_hi    <= '0;
    end else begin
      // Counter advances first; a write to either half below overrides just that half.
      mcycle_lo <= mcycle_lo + 32'd1;
      mcycle_hi <= mcycle_hi + {31'b0, &mcycle_lo};
      if (w_enable) begin
        case (csr_w_addr)
          A_MSTATUS: begin
            mstatus_mie  <= csr_result[3];
            mstatus_mpie <= csr_result[7];
          end
          A_MIE:      mie_q      <= csr_result;
          A_MTVEC:    mtvec_q    <= csr_result;
          A_MSCRATCH: mscratch_q <= csr_result;
          A_MEPC:     mepc_q     <= {csr_result[DATA_W-1:2], 2'b00};
          A_MCAUSE:   mcause_q   <= csr_result;
          A_MTVAL:    mtval_q    <= csr_result;
          A_MIP:      mip_q      <= csr_result;
          A_MCYCLE:   mcycle_lo  <= csr_result;
          A_MCYCLEH:  mcycle_hi  <= csr_result;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_csr_exec_unit.sv
// Directed bench for alu_csr_exec_unit: ALU ops, CSR mask generation,
// CSR file writes/bypass, counter behaviour and asynchronous reset.
module tb_alu_csr_exec_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  alu_op;
  logic [31:0] src1, src2, alu_result;
  logic [2:0]  csr_funct;
  logic [31:0] csr_val, rs1_val, imm, csr_result;
  logic [11:0] csr_r_addr, csr_w_addr;
  logic [31:0] csr_r_val;
  logic        w_enable;
  logic [31:0] debug_mstatus, debug_misa;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] snap;

  alu_csr_exec_unit dut (
    .clock         (clock),
    .reset         (reset),
    .alu_op        (alu_op),
    .src1          (src1),
    .src2          (src2),
    .alu_result    (alu_result),
    .csr_funct     (csr_funct),
    .csr_val       (csr_val),
    .rs1_val       (rs1_val),
    .imm           (imm),
    .csr_result    (csr_result),
    .csr_r_addr    (csr_r_addr),
    .csr_r_val     (csr_r_val),
    .csr_w_addr    (csr_w_addr),
    .w_enable      (w_enable),
    .debug_mstatus (debug_mstatus),
    .debug_misa    (debug_misa)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic alu_chk(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    alu_op = op; src1 = a; src2 = b;
    #1 check(tag, alu_result, exp);
  endtask

  task automatic mask_chk(input string tag, input logic [2:0] f, input logic [31:0] exp);
    csr_funct = f;
    #1 check(tag, csr_result, exp);
  endtask

  // CSRRW of val into addr, committed on the next rising edge.
  task automatic wr_csr(input logic [11:0] addr, input logic [31:0] val);
    @(negedge clock);
    csr_funct = 3'b001; rs1_val = val; csr_w_addr = addr; w_enable = 1'b1;
    @(posedge clock);
    #1 w_enable = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    csr_r_addr = addr;
    #1 check(tag, csr_r_val, exp);
  endtask

  initial begin
    reset = 1'b0; alu_op = '0; src1 = '0; src2 = '0;
    csr_funct = '0; csr_val = '0; rs1_val = '0; imm = '0;
    csr_r_addr = '0; csr_w_addr = '0; w_enable = 1'b0;
    #12 reset = 1'b1;

    #1 check("rst_mstatus", debug_mstatus, 32'h0000_1800);
    check("rst_misa", debug_misa, 32'h4000_0100);
    rd_chk("rst_mscratch", 12'h340, 32'h0);

    alu_chk("alu_sub",  4'd1,  32'd5,         32'd7,         32'hFFFF_FFFE);
    alu_chk("alu_sra",  4'd7,  32'h8000_0000, 32'h21,        32'hC000_0000);
    alu_chk("alu_slt",  4'd3,  32'hFFFF_FFFF, 32'd1,         32'd1);
    alu_chk("alu_sltu", 4'd4,  32'hFFFF_FFFF, 32'd1,         32'd0);
    alu_chk("alu_none", 4'd15, 32'h1234_5678, 32'h1111_1111, 32'd0);
    alu_chk("alu_add",  4'd0,  32'hFFFF_FFFF, 32'd2,         32'd1);
    alu_chk("alu_sll",  4'd2,  32'h0000_0003, 32'h24,        32'h0000_0030);
    alu_chk("alu_srl",  4'd6,  32'h8000_0000, 32'd4,         32'h0800_0000);
    alu_chk("alu_xor",  4'd5,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F);
    alu_chk("alu_eq",   4'd10, 32'hABCD_0000, 32'hABCD_0000, 32'd1);
    alu_chk("alu_ne",   4'd11, 32'hABCD_0000, 32'hABCD_0000, 32'd0);
    alu_chk("alu_ge",   4'd12, 32'hFFFF_FFFF, 32'd0,         32'd0);
    alu_chk("alu_geu",  4'd13, 32'hFFFF_FFFF, 32'd0,         32'd1);
    alu_chk("alu_rsv",  4'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);

    csr_val = 32'h0000_F0F0; rs1_val = 32'h0000_00FF; imm = 32'hFFFF_FFF5;
    mask_chk("mask_rw",   3'b001, 32'h0000_00FF);
    mask_chk("mask_rs",   3'b010, 32'h0000_F0FF);
    mask_chk("mask_rc",   3'b011, 32'h0000_F000);
    mask_chk("mask_rwi",  3'b101, 32'h0000_0015);
    mask_chk("mask_rsi",  3'b110, 32'h0000_F0F5);
    mask_chk("mask_rci",  3'b111, 32'h0000_F0E0);
    mask_chk("mask_000",  3'b000, 32'h0000_F0F0);
    mask_chk("mask_100",  3'b100, 32'h0000_F0F0);

    @(negedge clock);
    csr_funct = 3'b001; rs1_val = 32'hDEAD_BEEF; csr_w_addr = 12'h340;
    w_enable = 1'b1; csr_r_addr = 12'h340;
    #1 check("bypass_mscratch", csr_r_val, 32'hDEAD_BEEF);
    @(posedge clock);
    #1 w_enable = 1'b0;
    rd_chk("mscratch_after", 12'h340, 32'hDEAD_BEEF);

    wr_csr(12'h300, 32'hFFFF_FFFF);
    rd_chk("mstatus_masked", 12'h300, 32'h0000_1888);
    check("dbg_mstatus", debug_mstatus, 32'h0000_1888);
    wr_csr(12'h301, 32'h0000_0000);
    rd_chk("misa_ro", 12'h301, 32'h4000_0100);
    wr_csr(12'h7C0, 32'h1234_5678);
    rd_chk("unimpl_rd", 12'h7C0, 32'h0);
    check("misa_dbg", debug_misa, 32'h4000_0100);
    wr_csr(12'h341, 32'h0000_1003);
    rd_chk("mepc_align", 12'h341, 32'h0000_1000);
    rd_chk("mhartid", 12'hF14, 32'h0);

    @(negedge clock);
    csr_r_addr = 12'hB00;
    #1 snap = csr_r_val;
    @(negedge clock);
    #1 check("mcycle_inc", csr_r_val, snap + 32'd1);
    @(negedge clock);
    rd_chk("cycle_alias", 12'hC00, snap + 32'd2);

    wr_csr(12'hB00, 32'hFFFF_FFFF);
    rd_chk("mcycle_wr", 12'hB00, 32'hFFFF_FFFF);
    csr_r_addr = 12'hB80;
    #1 snap = csr_r_val;
    @(posedge clock);
    #1 rd_chk("mcycle_wrap", 12'hB00, 32'h0);
    rd_chk("mcycleh_carry", 12'hB80, snap + 32'd1);

    @(negedge clock);
    #2 reset = 1'b0;
    #1 check("async_rst_mstatus", debug_mstatus, 32'h0000_1800);
    check("async_rst_misa", debug_misa, 32'h4000_0100);
    rd_chk("async_rst_mscratch", 12'h340, 32'h0);
    rd_chk("async_rst_mepc", 12'h341, 32'h0);
    reset = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
